// File: rtl/bit_pipe_pkg.sv
// bit_pipe_pkg
// Shared types and helpers for the bit-level pipeline valid-token controller.
//   state_t  : controller FSM encoding (IDLE / RUN / DRAIN)
//   popcount : number of set bits in a token-valid vector (up to MAX_STAGES)
package bit_pipe_pkg;

    localparam int MAX_STAGES = 32;
    localparam int CNT_RES_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    // Callers zero-extend their STAGES-wide valid vector to MAX_STAGES.
    function automatic logic [CNT_RES_W-1:0] popcount(input logic [MAX_STAGES-1:0] vec);
        logic [CNT_RES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            cnt = cnt + {{(CNT_RES_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_pipe_tok.sv
// bit_pipe_tok
// Valid/last token for one datapath register bank.
//   clk, rst_n     : clock, async active-low reset
//   i_clr          : synchronous flush of this token
//   i_prev_v       : upstream token valid (bank 0: accepted input word)
//   i_prev_l       : upstream last bit (bank 0: in_last)
//   i_ready_next   : ready of the downstream bank (r[i+1])
//   o_v, o_l       : token valid / last-word flag held by this bank
//   o_ready        : r[i], this bank can take a word this cycle
//   o_en           : clock enable for this bank's datapath registers
module bit_pipe_tok (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_prev_v,
    input  logic i_prev_l,
    input  logic i_ready_next,
    output logic o_v,
    output logic o_l,
    output logic o_ready,
    output logic o_en
);

    logic r_v;
    logic r_l;

    // An empty bank is always ready, which is what collapses bubbles.
    assign o_ready = !r_v | i_ready_next;
    assign o_en    = o_ready & i_prev_v & !i_clr;

    // NOTE: state registers use non-blocking assignments so every bank samples
    // its neighbours' pre-edge values, giving true shift-register behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_l <= 1'b0;
        end else if (i_clr) begin
            r_v <= 1'b0;
            r_l <= 1'b0;
        end else if (o_en) begin
            r_v <= 1'b1;
            r_l <= i_prev_l;
        end else if (i_ready_next) begin
            // Word moved on and nothing replaced it; last bit is left as-is.
            r_v <= 1'b0;
        end
    end

    assign o_v = r_v;
    assign o_l = r_l;

endmodule

// File: rtl/bit_pipe_ctrl.sv
// bit_pipe_ctrl
// Valid-token controller sequencing a STAGES-deep bit-level pipelined datapath.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream elastic handshake, in_last marks frame end
//   flush                 : synchronous abort of every in-flight word
//   out_valid/out_ready   : downstream handshake, out_last marks frame end
//   stage_en[STAGES]      : per-bank clock enable, bit 0 is the input bank
//   stage_clr             : shared clear to all bank flip-flops
//   occupancy             : number of valid words in flight
//   busy                  : frame in progress (state not IDLE)
//   done                  : one-cycle pulse after the frame's last word leaves
module bit_pipe_ctrl
    import bit_pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [STAGES-1:0] stage_en,
    output logic              stage_clr,
    output logic [CNT_W-1:0]  occupancy,
    output logic              busy,
    output logic              done
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_done;
    logic   w_done_nxt;

    logic [STAGES:0]   w_r;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_l;
    logic [STAGES-1:0] w_prev_v;
    logic [STAGES-1:0] w_prev_l;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_r[STAGES] = out_ready;
    assign in_ready    = w_r[0] & (r_state != DRAIN) & !flush;
    assign w_in_fire   = in_valid & in_ready;

    // Bank 0 is fed by the input handshake, every other bank by its predecessor.
    assign w_prev_v = {w_v[STAGES-2:0], w_in_fire};
    assign w_prev_l = {w_l[STAGES-2:0], in_last};

    for (genvar g = 0; g < STAGES; g++) begin : g_tok
        bit_pipe_tok u_tok (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clr        (flush),
            .i_prev_v     (w_prev_v[g]),
            .i_prev_l     (w_prev_l[g]),
            .i_ready_next (w_r[g+1]),
            .o_v          (w_v[g]),
            .o_l          (w_l[g]),
            .o_ready      (w_r[g]),
            .o_en         (stage_en[g])
        );
    end

    assign out_valid  = w_v[STAGES-1];
    assign out_last   = w_l[STAGES-1];
    assign w_out_fire = out_valid & out_ready;
    assign stage_clr  = flush;

    // Derived from the token registers, so it is a clean registered count.
    assign occupancy = CNT_W'(popcount({{(MAX_STAGES-STAGES){1'b0}}, w_v}));

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_in_fire) w_state_nxt = in_last ? DRAIN : RUN;
                end
                RUN: begin
                    if (w_in_fire && in_last) w_state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (w_out_fire && out_last) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_bit_pipe_ctrl.sv
// tb_bit_pipe_ctrl
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against an ordered-queue model of the words in flight.
module tb_bit_pipe_ctrl;

    localparam int S = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [S-1:0]  stage_en;
    logic          stage_clr;
    logic [CW-1:0] occupancy;
    logic          busy;
    logic          done;

    bit_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .stage_en  (stage_en),
        .stage_clr (stage_clr),
        .occupancy (occupancy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    // Model: words in flight, oldest first, each with its bank position.
    typedef struct {
        int pos;
        bit last;
    } word_t;

    word_t  q[$];
    bit     m_lbank[S];   // last flag most recently written into each bank
    bit     m_open;       // frame started, last word not yet accepted
    bit     m_pend;       // last word accepted, not yet delivered
    bit     m_done;

    task automatic model_clear();
        q.delete();
        foreach (m_lbank[i]) m_lbank[i] = 1'b0;
        m_open = 1'b0;
        m_pend = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic do_cycle(input bit iv, input bit il, input bit ordy, input bit fl);
        int          np[$];
        int          bound;
        bit          e_in_ready, e_fire, e_ov, e_ol, e_out_fire, done_nxt;
        logic [S-1:0] e_en;

        @(negedge clk);
        in_valid  = iv;
        in_last   = il;
        out_ready = ordy;
        flush     = fl;
        #1;

        // Each word advances one bank unless it would collide with the new
        // position of the word ahead; the oldest may leave when out_ready.
        bound = ordy ? S : S - 1;
        foreach (q[i]) begin
            int n;
            n = q[i].pos + 1;
            if (n > bound) n = bound;
            np.push_back(n);
            bound = n - 1;
        end
        e_in_ready = !fl && !m_pend && (bound >= 0);
        e_fire     = iv && e_in_ready;
        e_ov       = (q.size() > 0) && (q[0].pos == S - 1);
        e_ol       = m_lbank[S-1];
        e_en       = '0;
        if (!fl) begin
            foreach (q[i]) if (np[i] != q[i].pos && np[i] < S) e_en[np[i]] = 1'b1;
            if (e_fire) e_en[0] = 1'b1;
        end

        check("in_ready", in_ready, e_in_ready);
        check("out_valid", out_valid, e_ov);
        check("out_last", out_last, e_ol);
        check("stage_en", stage_en, e_en);
        check("stage_clr", stage_clr, fl);
        check("occupancy", occupancy, q.size());
        check("busy", busy, m_open || m_pend);
        check("done", done, m_done);

        @(posedge clk);
        e_out_fire = e_ov && ordy;
        if (fl) begin
            model_clear();
        end else begin
            done_nxt = e_out_fire && q[0].last && m_pend;
            if (e_out_fire && q[0].last) m_pend = 1'b0;
            foreach (q[i]) begin
                if (np[i] != q[i].pos && np[i] < S) m_lbank[np[i]] = q[i].last;
                q[i].pos = np[i];
            end
            if (q.size() > 0 && q[0].pos == S) void'(q.pop_front());
            if (e_fire) begin
                q.push_back('{pos: 0, last: il});
                m_lbank[0] = il;
                if (il) begin
                    m_pend = 1'b1;
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
            m_done = done_nxt;
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream: words in banks 3,2,1, then asynchronous reset.
        do_cycle(0, 0, 0, 0);
        repeat (3) do_cycle(1, 0, 0, 0);
        do_cycle(0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stage_en", stage_en, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        do_cycle(0, 0, 1, 0);

        // Streaming frame of 8 words at full rate.
        for (int i = 0; i < 8; i++) do_cycle(1, i == 7, 1, 0);
        repeat (6) do_cycle(0, 0, 1, 0);

        // Backpressure, then release.
        for (int i = 0; i < 7; i++) do_cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) do_cycle(1, i == 5, 1, 0);
        repeat (8) do_cycle(0, 0, 1, 0);

        // Bubble collapse behind a stalled output word.
        do_cycle(1, 0, 0, 0);
        repeat (4) do_cycle(0, 0, 0, 0);
        do_cycle(1, 0, 0, 0);
        repeat (3) do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 1, 1);

        // Short frame drain with done pulse.
        for (int i = 0; i < 3; i++) do_cycle(1, i == 2, 1, 0);
        repeat (6) do_cycle(1, 0, 1, 0);

        // Flush with three words in flight and input pending.
        do_cycle(0, 0, 1, 1);
        repeat (3) do_cycle(1, 0, 0, 0);
        do_cycle(1, 0, 1, 1);
        do_cycle(0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
